// File: rtl/toggle_cover_gen.sv
// Per-bit toggle detector feeding the toggle-coverage reporter: rise/fall hit pulses,
// a sticky covered mask, a running popcount of that mask and an all-covered flag.
module toggle_cover_gen #(
  parameter int WIDTH = 32,
  parameter int ONCE  = 1,
  parameter int CW    = $clog2(2*WIDTH+1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     sig,
  output logic [2*WIDTH-1:0]   valid,
  output logic [2*WIDTH-1:0]   covered,
  output logic [CW-1:0]        count,
  output logic                 all_covered
);

  logic [WIDTH-1:0]   prev_reg;
  logic               armed_reg;
  logic [2*WIDTH-1:0] valid_reg, valid_next;
  logic [2*WIDTH-1:0] covered_reg, covered_next;
  logic [CW-1:0]      count_reg, count_next;
  logic               all_reg, all_next;

  logic [2*WIDTH-1:0] raw;
  logic [2*WIDTH-1:0] hit;
  logic [2*WIDTH-1:0] new_hits;
  logic [CW-1:0]      new_pop;

  // Even bit = rise, odd bit = fall of the same monitored signal.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_raw
      assign raw[2*gi]   =  sig[gi] & ~prev_reg[gi];
      assign raw[2*gi+1] = ~sig[gi] &  prev_reg[gi];
    end
  endgenerate

  assign hit      = (armed_reg && en) ? raw : '0;
  assign new_hits = hit & ~covered_reg;

  always_comb begin
    new_pop = '0;
    for (int i = 0; i < 2*WIDTH; i++) begin
      new_pop = new_pop + CW'(new_hits[i]);
    end
  end

  // Clear takes priority over any hit landing in the same cycle.
  always_comb begin
    valid_next   = '0;
    covered_next = '0;
    count_next   = '0;
    if (!clear) begin
      valid_next   = (ONCE != 0) ? new_hits : hit;
      covered_next = covered_reg | hit;
      count_next   = count_reg + new_pop;
    end
    all_next = (count_next == CW'(2*WIDTH));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_reg    <= '0;
      armed_reg   <= 1'b0;
      valid_reg   <= '0;
      covered_reg <= '0;
      count_reg   <= '0;
      all_reg     <= 1'b0;
    end else begin
      prev_reg    <= sig;
      armed_reg   <= 1'b1;
      valid_reg   <= valid_next;
      covered_reg <= covered_next;
      count_reg   <= count_next;
      all_reg     <= all_next;
    end
  end

  assign valid       = valid_reg;
  assign covered     = covered_reg;
  assign count       = count_reg;
  assign all_covered = all_reg;

endmodule
